address_table: RTL and testbench

//  Switch MAC learning table. Learns (48-bit MAC -> egress port) pairs and answers lookups.

---
 rtl/address_table.sv | 105 ++++++++++
 tb/tb_address_table.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/address_table.sv
// MAC learning table: learns (address -> egress port) pairs, answers lookups
// combinationally, and keeps a saturating read count per entry. When the
// table is full, the least-read entry is replaced by the next new address.
module address_table #(
    parameter int NUM_PORTS   = 4,
    parameter int NUM_ENTRIES = 16,
    parameter int CNT_W       = 16,
    localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          learn_req_i,
    input  logic [47:0]   learn_address_i,
    input  logic [PW-1:0] learn_port_i,
    input  logic          read_req_i,
    input  logic [47:0]   read_address_i,
    output logic [PW-1:0] read_port_o,
    output logic          read_port_valid_o
);

    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [47:0]            addr_q [NUM_ENTRIES];
    logic [PW-1:0]          port_q [NUM_ENTRIES];
    logic [CNT_W-1:0]       cnt_q  [NUM_ENTRIES];

    logic          rd_hit;
    logic [IW-1:0] rd_idx;
    logic          ln_hit;
    logic [IW-1:0] ln_idx;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          victim_found;
    logic [IW-1:0] victim_idx;
    logic [CNT_W-1:0] min_cnt;
    logic [IW-1:0] wr_idx;

    // Match, free-slot and victim search, all on the pre-edge table contents.
    // Strict '<' in the victim scan keeps ties on the lowest index.
    always_comb begin
        rd_hit       = 1'b0;
        rd_idx       = '0;
        ln_hit       = 1'b0;
        ln_idx       = '0;
        free_found   = 1'b0;
        free_idx     = '0;
        victim_found = 1'b0;
        victim_idx   = '0;
        min_cnt      = '1;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && !rd_hit && addr_q[i] == read_address_i) begin
                rd_hit = 1'b1;
                rd_idx = IW'(i);
            end
            if (valid_q[i] && !ln_hit && addr_q[i] == learn_address_i) begin
                ln_hit = 1'b1;
                ln_idx = IW'(i);
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (valid_q[i] && (!victim_found || cnt_q[i] < min_cnt)) begin
                victim_found = 1'b1;
                victim_idx   = IW'(i);
                min_cnt      = cnt_q[i];
            end
        end
        wr_idx = free_found ? free_idx : victim_idx;
    end

    // Zero-latency lookup result; port forced to 0 on a miss.
    always_comb begin
        read_port_valid_o = read_req_i && rd_hit;
        read_port_o       = read_port_valid_o ? port_q[rd_idx] : '0;
    end

    // Table update. The learn write comes after the read increment so that
    // replacing the entry being read discards that increment (count restarts
    // at 0), while a port-only relearn leaves the increment in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (read_req_i && rd_hit && cnt_q[rd_idx] != '1) begin
                cnt_q[rd_idx] <= cnt_q[rd_idx] + CNT_W'(1);
            end
            if (learn_req_i) begin
                if (ln_hit) begin
                    port_q[ln_idx] <= learn_port_i;
                end else begin
                    valid_q[wr_idx] <= 1'b1;
                    addr_q[wr_idx]  <= learn_address_i;
                    port_q[wr_idx]  <= learn_port_i;
                    cnt_q[wr_idx]   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_address_table.sv
// Bench for address_table: directed scenarios followed by random learn/read
// traffic, every cycle compared against a behavioural table model.
module tb_address_table;

    localparam int NP    = 4;
    localparam int NE    = 16;
    localparam int CW    = 4;
    localparam int PW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          learn_req_i;
    logic [47:0]   learn_address_i;
    logic [PW-1:0] learn_port_i;
    logic          read_req_i;
    logic [47:0]   read_address_i;
    logic [PW-1:0] read_port_o;
    logic          read_port_valid_o;

    int checks = 0;
    int errors = 0;

    // Reference model: a list of slots holding address, port and read count.
    bit          m_valid [NE];
    logic [47:0] m_addr  [NE];
    int          m_port  [NE];
    int          m_cnt   [NE];

    address_table #(.NUM_PORTS(NP), .NUM_ENTRIES(NE), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .learn_req_i       (learn_req_i),
        .learn_address_i   (learn_address_i),
        .learn_port_i      (learn_port_i),
        .read_req_i        (read_req_i),
        .read_address_i    (read_address_i),
        .read_port_o       (read_port_o),
        .read_port_valid_o (read_port_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input logic [47:0] a);
        for (int i = 0; i < NE; i++)
            if (m_valid[i] && m_addr[i] == a) return i;
        return -1;
    endfunction

    // Slot a new address lands in: first empty slot, else the least-read one
    // (earliest slot on a tie).
    function automatic int m_target();
        int best = -1;
        for (int i = 0; i < NE; i++)
            if (!m_valid[i]) return i;
        for (int i = 0; i < NE; i++)
            if (best < 0 || m_cnt[i] < m_cnt[best]) best = i;
        return best;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 0;
            m_port[i]  = 0;
            m_addr[i]  = '0;
        end
    endtask

    task automatic m_edge(input bit rst, input bit lr, input logic [47:0] la, input int lp,
                          input bit rr, input logic [47:0] ra);
        int r, l, t;
        if (rst) begin
            m_clear();
            return;
        end
        r = rr ? m_find(ra) : -1;
        l = lr ? m_find(la) : -1;
        t = (lr && l < 0) ? m_target() : -1;
        if (r >= 0 && m_cnt[r] < CMAX) m_cnt[r]++;
        if (lr) begin
            if (l >= 0) m_port[l] = lp;
            else begin
                m_valid[t] = 1;
                m_addr[t]  = la;
                m_port[t]  = lp;
                m_cnt[t]   = 0;
            end
        end
    endtask

    // One clock: drive at the falling edge, compare lookup outputs against
    // the model's pre-edge state, then advance the model past the rising edge.
    task automatic cycle(input bit rst, input bit lr, input logic [47:0] la, input int lp,
                         input bit rr, input logic [47:0] ra, input string tag);
        int r;
        @(negedge clk);
        rst_n           = !rst;
        learn_req_i     = lr;
        learn_address_i = la;
        learn_port_i    = PW'(lp);
        read_req_i      = rr;
        read_address_i  = ra;
        #1;
        r = rr ? m_find(ra) : -1;
        check({tag, "_valid"}, 64'(read_port_valid_o), 64'(r >= 0));
        check({tag, "_port"}, 64'(read_port_o), (r >= 0) ? 64'(m_port[r]) : 64'd0);
        @(posedge clk);
        m_edge(rst, lr, la, lp, rr, ra);
    endtask

    task automatic do_reset();
        cycle(1, 0, '0, 0, 0, '0, "reset");
    endtask

    task automatic do_learn(input logic [47:0] a, input int p);
        cycle(0, 1, a, p, 0, '0, "learn");
    endtask

    task automatic do_read(input logic [47:0] a, input string tag);
        cycle(0, 0, '0, 0, 1, a, tag);
    endtask

    task automatic expect_hit(input logic [47:0] a, input bit hit, input string tag);
        @(negedge clk);
        rst_n          = 1'b1;
        learn_req_i    = 1'b0;
        read_req_i     = 1'b1;
        read_address_i = a;
        #1;
        check(tag, 64'(read_port_valid_o), 64'(hit));
        @(posedge clk);
        m_edge(0, 0, '0, 0, 1, a);
    endtask

    initial begin
        m_clear();
        rst_n           = 1'b0;
        learn_req_i     = 1'b0;
        learn_address_i = '0;
        learn_port_i    = '0;
        read_req_i      = 1'b0;
        read_address_i  = '0;

        // Scenario 1: empty table misses, single learn then hit.
        do_reset();
        do_reset();
        expect_hit(48'h1001, 0, "s1_empty_miss");
        do_learn(48'h1001, 1);
        expect_hit(48'h1001, 1, "s1_hit");
        do_read(48'h1001, "s1_port");

        // Scenario 2: fill table, read all back, miss on an absent address.
        do_reset();
        for (int i = 1; i <= 16; i++) do_learn(48'h1000 + 48'(i), i % 4);
        for (int i = 1; i <= 16; i++) do_read(48'h1000 + 48'(i), "s2_read");
        expect_hit(48'h1011, 0, "s2_absent_miss");

        // Scenario 3: entry for 0x1000+i gets i-1 reads, then four evictions.
        do_reset();
        for (int i = 1; i <= 16; i++) do_learn(48'h1000 + 48'(i), i % 4);
        for (int i = 1; i <= 16; i++)
            for (int k = 0; k < i - 1; k++) do_read(48'h1000 + 48'(i), "s3_bump");
        for (int i = 17; i <= 20; i++) do_learn(48'h1000 + 48'(i), i % 4);
        for (int i = 1; i <= 20; i++) do_read(48'h1000 + 48'(i), "s3_probe");

        // Scenario 4: heavier reads on 0x1008..0x100B, then four more evictions.
        for (int i = 8; i <= 11; i++)
            for (int k = 0; k < 10; k++) do_read(48'h1000 + 48'(i), "s4_bump");
        for (int i = 21; i <= 24; i++) do_learn(48'h1000 + 48'(i), i % 4);
        for (int i = 8; i <= 11; i++) expect_hit(48'h1000 + 48'(i), 1, "s4_kept");
        expect_hit(48'h1010, 1, "s4_kept_1010");
        for (int i = 1; i <= 24; i++) do_read(48'h1000 + 48'(i), "s4_probe");

        // Scenario 5: relearn existing address updates port only.
        do_learn(48'h1005, 3);
        do_read(48'h1005, "s5_port");
        for (int i = 1; i <= 24; i++) do_read(48'h1000 + 48'(i), "s5_probe");

        // Same-cycle learn and read of a new address returns a miss.
        cycle(0, 1, 48'h2000, 2, 1, 48'h2000, "same_new");
        do_read(48'h2000, "same_new_after");

        // Scenario 6: one reset edge discards everything.
        do_reset();
        for (int i = 1; i <= 24; i++) expect_hit(48'h1000 + 48'(i), 0, "s6_miss");
        do_learn(48'h3000, 2);
        do_read(48'h3000, "s6_relearn");

        // Special addresses are ordinary keys.
        do_learn(48'h0, 1);
        do_learn(48'hFFFF_FFFF_FFFF, 3);
        do_read(48'h0, "addr_zero");
        do_read(48'hFFFF_FFFF_FFFF, "addr_bcast");

        // Random traffic over a pool larger than the table to force evictions,
        // saturation, and same-cycle learn/read collisions.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit rst, lr, rr;
            logic [47:0] la, ra;
            int lp;
            rst = ($urandom_range(0, 299) == 0);
            lr  = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 3) != 0);
            la  = 48'h1000 + 48'($urandom_range(0, 23));
            ra  = ($urandom_range(0, 3) == 0) ? la : 48'h1000 + 48'($urandom_range(0, 23));
            lp  = $urandom_range(0, NP - 1);
            cycle(rst, lr, la, lp, rr, ra, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
